// File: rtl/md4_engine.sv
`default_nettype none
// md4_engine: MD4 / NTLM hash engine, byte-stream in, 128-bit digest out, 1/2/4 steps per cycle.
// Optional MD4_ENGINE_CMP_EN adds TARGET_IN and a registered MATCH_OUT comparator.
module md4_engine #(
  parameter int STEPS_PER_CYCLE = 1,
  parameter int LEN_W           = 32
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             START_IN,
  input  logic             NTLM_IN,
  input  logic [LEN_W-1:0] LEN_IN,
  input  logic [7:0]       IN_DATA,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic             BUSY_OUT,
  output logic [127:0]     DIGEST_OUT,
  output logic             DIGEST_VALID,
  input  logic             DIGEST_READY
`ifdef MD4_ENGINE_CMP_EN
  ,
  input  logic [127:0]     TARGET_IN,
  output logic             MATCH_OUT
`endif
);

  localparam int S         = STEPS_PER_CYCLE;
  localparam int LAST_STEP = 48 - S;

  localparam logic [31:0] IV_A = 32'h67452301;
  localparam logic [31:0] IV_B = 32'hefcdab89;
  localparam logic [31:0] IV_C = 32'h98badcfe;
  localparam logic [31:0] IV_D = 32'h10325476;

  if (!(S == 1 || S == 2 || S == 4)) begin : g_bad_steps
    $error("md4_engine: STEPS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_PAD   = 3'd2,
    ST_ROUND = 3'd3,
    ST_ADD   = 3'd4,
    ST_OUT   = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic             ntlm_q;
  logic [LEN_W-1:0] rem_q;
  logic [LEN_W:0]   efflen_q;
  logic [6:0]       ptr_q;
  logic [511:0]     blk_q;
  logic [31:0]      a_q, b_q, c_q, d_q;
  logic [31:0]      wa_q, wb_q, wc_q, wd_q;
  logic [5:0]       step_q;
  logic             padded_q;
  logic             last_q;

  logic             accept;
  logic [63:0]      bitlen;
  logic [31:0]      sum_a, sum_b, sum_c, sum_d;

  function automatic logic [3:0] word_sel(input logic [5:0] i);
    logic [3:0] j;
    j = i[3:0];
    case (i[5:4])
      2'd0:    word_sel = j;
      2'd1:    word_sel = {j[1:0], j[3:2]};
      default: word_sel = {j[0], j[1], j[2], j[3]};
    endcase
  endfunction

  function automatic logic [4:0] shamt(input logic [5:0] i);
    case ({i[5:4], i[1:0]})
      4'b0000: shamt = 5'd3;
      4'b0001: shamt = 5'd7;
      4'b0010: shamt = 5'd11;
      4'b0011: shamt = 5'd19;
      4'b0100: shamt = 5'd3;
      4'b0101: shamt = 5'd5;
      4'b0110: shamt = 5'd9;
      4'b0111: shamt = 5'd13;
      4'b1000: shamt = 5'd3;
      4'b1001: shamt = 5'd9;
      4'b1010: shamt = 5'd11;
      default: shamt = 5'd15;
    endcase
  endfunction

  function automatic logic [31:0] bool_f(input logic [5:0] i, input logic [31:0] b,
                                         input logic [31:0] c, input logic [31:0] d);
    case (i[5:4])
      2'd0:    bool_f = (b & c) | (~b & d);
      2'd1:    bool_f = (b & c) | (b & d) | (c & d);
      default: bool_f = b ^ c ^ d;
    endcase
  endfunction

  function automatic logic [31:0] round_k(input logic [5:0] i);
    case (i[5:4])
      2'd0:    round_k = 32'h00000000;
      2'd1:    round_k = 32'h5a827999;
      default: round_k = 32'h6ed9eba1;
    endcase
  endfunction

  function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] s);
    logic [63:0] t;
    t = {x, x} << s;
    return t[63:32];
  endfunction

  // Chain of S combinational steps; the tuple rotates (a,b,c,d) -> (d,a',b,c) after each step.
  logic [31:0] ra [S+1];
  logic [31:0] rb [S+1];
  logic [31:0] rc [S+1];
  logic [31:0] rd [S+1];

  assign ra[0] = wa_q;
  assign rb[0] = wb_q;
  assign rc[0] = wc_q;
  assign rd[0] = wd_q;

  for (genvar g = 0; g < S; g++) begin : g_step
    logic [5:0]  idx;
    logic [31:0] x;
    logic [31:0] sum;
    assign idx     = step_q + 6'(g);
    assign x       = blk_q[{word_sel(idx), 5'b00000} +: 32];
    assign sum     = ra[g] + bool_f(idx, rb[g], rc[g], rd[g]) + x + round_k(idx);
    assign ra[g+1] = rd[g];
    assign rb[g+1] = rotl(sum, shamt(idx));
    assign rc[g+1] = rb[g];
    assign rd[g+1] = rc[g];
  end

  assign accept = IN_VALID & IN_READY;
  assign bitlen = 64'(efflen_q) << 3;
  assign sum_a  = a_q + wa_q;
  assign sum_b  = b_q + wb_q;
  assign sum_c  = c_q + wc_q;
  assign sum_d  = d_q + wd_q;

  always_ff @(posedge CLK) begin
    if (!RESET_N) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    IN_READY     = 1'b0;
    BUSY_OUT     = (state_q != ST_IDLE);
    DIGEST_VALID = 1'b0;
    DIGEST_OUT   = '0;
    case (state_q)
      ST_IDLE:  if (START_IN) state_d = ST_LOAD;
      ST_LOAD: begin
        IN_READY = (rem_q != '0) && !ptr_q[6];
        if (ptr_q[6])          state_d = ST_ROUND;
        else if (rem_q == '0)  state_d = ST_PAD;
      end
      ST_PAD:   state_d = ST_ROUND;
      ST_ROUND: if (step_q == 6'(LAST_STEP)) state_d = ST_ADD;
      ST_ADD: begin
        // A full final block leaves padding (or the length-only block) still to do.
        if (rem_q != '0)  state_d = ST_LOAD;
        else if (!last_q) state_d = ST_PAD;
        else              state_d = ST_OUT;
      end
      ST_OUT: begin
        DIGEST_VALID = 1'b1;
        DIGEST_OUT   = {d_q, c_q, b_q, a_q};
        if (DIGEST_READY) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      ntlm_q   <= 1'b0;
      rem_q    <= '0;
      efflen_q <= '0;
      ptr_q    <= '0;
      blk_q    <= '0;
      a_q      <= IV_A;
      b_q      <= IV_B;
      c_q      <= IV_C;
      d_q      <= IV_D;
      wa_q     <= IV_A;
      wb_q     <= IV_B;
      wc_q     <= IV_C;
      wd_q     <= IV_D;
      step_q   <= '0;
      padded_q <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (START_IN) begin
          ntlm_q   <= NTLM_IN;
          rem_q    <= LEN_IN;
          efflen_q <= NTLM_IN ? {LEN_IN, 1'b0} : {1'b0, LEN_IN};
          ptr_q    <= '0;
          blk_q    <= '0;
          a_q      <= IV_A;
          b_q      <= IV_B;
          c_q      <= IV_C;
          d_q      <= IV_D;
          wa_q     <= IV_A;
          wb_q     <= IV_B;
          wc_q     <= IV_C;
          wd_q     <= IV_D;
          step_q   <= '0;
          padded_q <= 1'b0;
          last_q   <= 1'b0;
        end
        ST_LOAD: if (accept) begin
          // The UTF-16LE high byte is already zero in the cleared buffer.
          blk_q[{ptr_q[5:0], 3'b000} +: 8] <= IN_DATA;
          ptr_q <= ptr_q + (ntlm_q ? 7'd2 : 7'd1);
          rem_q <= rem_q - LEN_W'(1);
        end
        ST_PAD: begin
          if (!padded_q) begin
            blk_q[{ptr_q[5:0], 3'b000} +: 8] <= 8'h80;
            padded_q <= 1'b1;
            if (ptr_q[5:0] <= 6'd55) begin
              blk_q[511:448] <= bitlen;
              last_q         <= 1'b1;
            end
          end else begin
            blk_q[511:448] <= bitlen;
            last_q         <= 1'b1;
          end
        end
        ST_ROUND: begin
          step_q <= step_q + 6'(S);
          wa_q   <= ra[S];
          wb_q   <= rb[S];
          wc_q   <= rc[S];
          wd_q   <= rd[S];
        end
        ST_ADD: begin
          a_q    <= sum_a;
          b_q    <= sum_b;
          c_q    <= sum_c;
          d_q    <= sum_d;
          wa_q   <= sum_a;
          wb_q   <= sum_b;
          wc_q   <= sum_c;
          wd_q   <= sum_d;
          blk_q  <= '0;
          ptr_q  <= '0;
          step_q <= '0;
        end
        default: ;
      endcase
    end
  end

`ifdef MD4_ENGINE_CMP_EN
  logic match_q;

  always_ff @(posedge CLK) begin
    if (!RESET_N)
      match_q <= 1'b0;
    else if (state_q == ST_ADD && state_d == ST_OUT)
      match_q <= ({sum_d, sum_c, sum_b, sum_a} == TARGET_IN);
    else if (state_q == ST_OUT && DIGEST_READY)
      match_q <= 1'b0;
  end

  assign MATCH_OUT = match_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_md4_engine.sv
`default_nettype none
// tb_md4_engine: known-answer and randomized checks of md4_engine at 1, 2 and 4 steps per cycle.
module tb_md4_engine;

  localparam int NU = 3;
  localparam int SH1 [4]  = '{3, 7, 11, 19};
  localparam int SH2 [4]  = '{3, 5, 9, 13};
  localparam int SH3 [4]  = '{3, 9, 11, 15};
  localparam int O2  [16] = '{0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15};
  localparam int O3  [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic         rstn [NU];
  logic         start, ntlm, in_valid, dig_ready;
  logic [31:0]  len;
  logic [7:0]   in_data;
  logic         in_ready [NU];
  logic         busy     [NU];
  logic         dvalid   [NU];
  logic [127:0] dig      [NU];
`ifdef MD4_ENGINE_CMP_EN
  logic [127:0] target;
  logic         match    [NU];
`endif

  int n_tests = 0;
  int n_fail  = 0;

  for (genvar g = 0; g < NU; g++) begin : g_dut
    md4_engine #(.STEPS_PER_CYCLE(1 << g), .LEN_W(32)) u_dut (
      .CLK          (clk),
      .RESET_N      (rstn[g]),
      .START_IN     (start),
      .NTLM_IN      (ntlm),
      .LEN_IN       (len),
      .IN_DATA      (in_data),
      .IN_VALID     (in_valid),
      .IN_READY     (in_ready[g]),
      .BUSY_OUT     (busy[g]),
      .DIGEST_OUT   (dig[g]),
      .DIGEST_VALID (dvalid[g]),
      .DIGEST_READY (dig_ready)
`ifdef MD4_ENGINE_CMP_EN
      ,
      .TARGET_IN    (target),
      .MATCH_OUT    (match[g])
`endif
    );
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Hex digest as usually printed (byte 0 first) -> DIGEST_OUT layout (byte 0 in bits 7:0).
  function automatic logic [127:0] canon(input logic [127:0] h);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = h[127-8*i -: 8];
    return r;
  endfunction

  task automatic str_q(input string s, output logic [7:0] q[$]);
    q = {};
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
  endtask

  function automatic logic [127:0] md4_model(input logic [7:0] msg[$], input bit nt);
    logic [7:0]  m[$];
    logic [31:0] h [4];
    logic [31:0] x [16];
    logic [31:0] a, b, c, d, f, t, kc;
    logic [63:0] bl;
    int k, s;
    foreach (msg[i]) begin
      m.push_back(msg[i]);
      if (nt) m.push_back(8'h00);
    end
    bl = 64'(m.size()) * 64'd8;
    m.push_back(8'h80);
    while (m.size() % 64 != 56) m.push_back(8'h00);
    for (int i = 0; i < 8; i++) m.push_back(bl[8*i +: 8]);
    h[0] = 32'h67452301; h[1] = 32'hefcdab89; h[2] = 32'h98badcfe; h[3] = 32'h10325476;
    for (int blk = 0; blk < m.size() / 64; blk++) begin
      for (int w = 0; w < 16; w++)
        x[w] = {m[64*blk+4*w+3], m[64*blk+4*w+2], m[64*blk+4*w+1], m[64*blk+4*w]};
      a = h[0]; b = h[1]; c = h[2]; d = h[3];
      for (int i = 0; i < 48; i++) begin
        case (i / 16)
          0: begin f = (b & c) | (~b & d);          k = i;          kc = 32'h0;        s = SH1[i%4]; end
          1: begin f = (b & c) | (b & d) | (c & d); k = O2[i%16];   kc = 32'h5a827999; s = SH2[i%4]; end
          default: begin f = b ^ c ^ d;             k = O3[i%16];   kc = 32'h6ed9eba1; s = SH3[i%4]; end
        endcase
        t = a + f + x[k] + kc;
        t = (t << s) | (t >> (32 - s));
        a = d; d = c; c = b; b = t;
      end
      h[0] += a; h[1] += b; h[2] += c; h[3] += d;
    end
    return {h[3], h[2], h[1], h[0]};
  endfunction

  task automatic run_hash(input int u, input logic [7:0] msg[$], input bit nt, input bit gaps,
                          input int hold, output logic [127:0] dg, output int lat, output bit mt);
    int  c0, n, idx;
    bit  acc, stable;
    string tg;
    tg = $sformatf("u%0d len%0d", u, msg.size());
    start = 1'b1; ntlm = nt; len = msg.size();
    @(posedge clk); #1;
    start = 1'b0; c0 = cyc; idx = 0; n = 0;
    while (idx < msg.size() && n < 5000) begin
      in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data  = msg[idx];
      acc      = in_valid && in_ready[u];
      @(posedge clk); #1;
      if (acc) idx++;
      n++;
    end
    in_valid = 1'b0;
    check_eq({tg, " bytes taken"}, 128'(idx), 128'(msg.size()));
    check_eq({tg, " ready after last"}, 128'(in_ready[u]), 128'(0));
    n = 0;
    while (!dvalid[u] && n < 3000) begin @(posedge clk); #1; n++; end
    check_eq({tg, " valid"}, 128'(dvalid[u]), 128'(1));
    lat = cyc - c0;
    dg  = dig[u];
`ifdef MD4_ENGINE_CMP_EN
    mt = match[u];
`else
    mt = 1'b0;
`endif
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      start = 1'b1;
      @(posedge clk); #1;
      if (dig[u] !== dg || dvalid[u] !== 1'b1) stable = 1'b0;
    end
    start = 1'b0;
    if (hold > 0) check_eq({tg, " hold stable"}, 128'(stable), 128'(1));
    dig_ready = 1'b1;
    @(posedge clk); #1;
    dig_ready = 1'b0;
    check_eq({tg, " idle after ack"}, 128'({busy[u], dvalid[u]}), 128'(0));
  endtask

  task automatic run_suite(input int u);
    logic [7:0]   q[$];
    logic [127:0] dg;
    int           lat, steps;
    bit           mt, nt;
    string        tg;
    steps = 48 >> u;
    tg    = $sformatf("u%0d", u);

    check_eq({tg, " reset ctl"}, 128'({busy[u], in_ready[u], dvalid[u]}), 128'(0));
    check_eq({tg, " reset digest"}, dig[u], 128'(0));
    rstn[u] = 1'b1;
    @(posedge clk); #1;

    q = {};
    run_hash(u, q, 1'b0, 1'b0, 0, dg, lat, mt);
    check_eq({tg, " empty"}, dg, canon(128'h31d6cfe0d16ae931b73c59d7e0c089c0));
    check_eq({tg, " empty latency"}, 128'(lat), 128'(steps + 3));

    str_q("abc", q);
    run_hash(u, q, 1'b0, 1'b0, 0, dg, lat, mt);
    check_eq({tg, " abc"}, dg, canon(128'ha448017aaf21d8525fc10ae87aa6729d));
    check_eq({tg, " abc latency"}, 128'(lat), 128'(steps + 6));
    run_hash(u, q, 1'b0, 1'b1, 20, dg, lat, mt);
    check_eq({tg, " abc gaps hold"}, dg, canon(128'ha448017aaf21d8525fc10ae87aa6729d));

    str_q("password", q);
    run_hash(u, q, 1'b1, 1'b1, 0, dg, lat, mt);
    check_eq({tg, " ntlm password"}, dg, canon(128'h8846f7eaee8fb117ad06bdd830b7586c));

    str_q("ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefghijklmnopqrstuvwxyz0123456789", q);
    run_hash(u, q, 1'b0, 1'b1, 1, dg, lat, mt);
    check_eq({tg, " alnum62"}, dg, canon(128'h043f8582f241db351ce627e153e7f0e4));

    q = {};
    for (int r = 0; r < 8; r++)
      for (int i = 0; i < 10; i++) q.push_back(8'h30 + 8'((i + 1) % 10));
    run_hash(u, q, 1'b0, 1'b1, 0, dg, lat, mt);
    check_eq({tg, " digits80"}, dg, canon(128'he33b4ddc9c38f2199c3e7b164fcc0536));

    // Abort in the middle of the compression rounds, then hash again from scratch.
    str_q("abc", q);
    start = 1'b1; ntlm = 1'b0; len = 3;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin in_data = q[i]; @(posedge clk); #1; end
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_eq({tg, " busy mid-round"}, 128'(busy[u]), 128'(1));
    rstn[u] = 1'b0;
    @(posedge clk); #1;
    check_eq({tg, " abort ctl"}, 128'({busy[u], in_ready[u], dvalid[u]}), 128'(0));
    check_eq({tg, " abort digest"}, dig[u], 128'(0));
    rstn[u] = 1'b1;
    @(posedge clk); #1;
    run_hash(u, q, 1'b0, 1'b1, 0, dg, lat, mt);
    check_eq({tg, " abc after abort"}, dg, canon(128'ha448017aaf21d8525fc10ae87aa6729d));

    for (int k = 0; k < 6; k++) begin
      int n;
      n  = $urandom_range(0, 140);
      nt = 1'($urandom_range(0, 1));
      q  = {};
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      run_hash(u, q, nt, 1'b1, $urandom_range(0, 3), dg, lat, mt);
      check_eq($sformatf("%s rand%0d len%0d ntlm%0d", tg, k, n, nt), dg, md4_model(q, nt));
    end

`ifdef MD4_ENGINE_CMP_EN
    str_q("abcdefghijklmnopqrstuvwxyz", q);
    target = canon(128'hd79e1c308aa5bbcdeea8ed63df412da9);
    run_hash(u, q, 1'b0, 1'b1, 0, dg, lat, mt);
    check_eq({tg, " match hit"}, 128'(mt), 128'(1));
    begin
      int b;
      b = $urandom_range(0, 127);
      target[b] = ~target[b];
    end
    run_hash(u, q, 1'b0, 1'b1, 0, dg, lat, mt);
    check_eq({tg, " match miss"}, 128'(mt), 128'(0));
`endif

    rstn[u] = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    start = 1'b0; ntlm = 1'b0; len = '0; in_data = '0; in_valid = 1'b0; dig_ready = 1'b0;
`ifdef MD4_ENGINE_CMP_EN
    target = '0;
`endif
    for (int u = 0; u < NU; u++) rstn[u] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < NU; u++) run_suite(u);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, %0d checks so far", n_tests);
    $fatal(1);
  end

endmodule
`default_nettype wire
